// File: rtl/cam_pkg.sv
// Shared types and helpers for the camera-to-framebuffer writer.
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } state_e;

    localparam int FB_W_DEF  = 160;
    localparam int FB_H_DEF  = 120;
    // Cycles spent in FLUSH so the two-stage write pipeline drains before a swap.
    localparam int FLUSH_CYC = 2;

    function automatic int calc_addr_w(input int banks, input int fb_w, input int fb_h);
        return $clog2(banks * fb_w * fb_h);
    endfunction

    // Multiply by a constant as a sum of shifted copies, so no multiplier is inferred.
    function automatic logic [31:0] mul_const(input logic [31:0] v, input int k);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            if (k[i]) acc = acc + (v << i);
        end
        return acc;
    endfunction

endpackage

// File: rtl/cam_fb_map.sv
// Stage 1 of the write pipeline: decimation keep test, scaling, mirror,
// flip, wrapping vertical offset and clipping, all registered.
module cam_fb_map
    import cam_pkg::*;
#(
    parameter int PIX_W = 16,
    parameter int FB_W  = FB_W_DEF,
    parameter int FB_H  = FB_H_DEF,
    parameter int DECIM = 2,
    parameter int CNT_W = 11,
    parameter int OFS_W = 7,
    parameter int X_W   = $clog2(FB_W),
    parameter int Y_W   = $clog2(FB_H)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [CNT_W-1:0] col_i,
    input  logic [CNT_W-1:0] row_i,
    input  logic             mirror_i,
    input  logic             flip_i,
    input  logic [OFS_W-1:0] yofs_i,
    input  logic [PIX_W-1:0] data_i,
    output logic             wr_o,
    output logic             clip_o,
    output logic [X_W-1:0]   x_o,
    output logic [Y_W-1:0]   y_o,
    output logic [PIX_W-1:0] data_o
);

    localparam logic [CNT_W-1:0] DMASK = CNT_W'((1 << DECIM) - 1);
    localparam logic [CNT_W-1:0] W_C   = CNT_W'(FB_W);
    localparam logic [CNT_W-1:0] H_C   = CNT_W'(FB_H);
    localparam logic [CNT_W-1:0] W_M1  = CNT_W'(FB_W - 1);
    localparam logic [CNT_W-1:0] H_M1  = CNT_W'(FB_H - 1);

    logic             keep, clip;
    logic [CNT_W-1:0] xs, ys, xm, yf, ysum;
    logic             wr_q, clip_q;
    logic [X_W-1:0]   x_q;
    logic [Y_W-1:0]   y_q;
    logic [PIX_W-1:0] data_q;
    logic             unused_hi;

    // Map raw (col,row) to framebuffer (x,y); offset is pre-clamped below FB_H so one subtract wraps it.
    always_comb begin
        xs   = col_i >> DECIM;
        ys   = row_i >> DECIM;
        keep = ((col_i & DMASK) == '0) && ((row_i & DMASK) == '0);
        clip = (xs >= W_C) || (ys >= H_C);
        xm   = mirror_i ? (W_M1 - xs) : xs;
        yf   = flip_i ? (H_M1 - ys) : ys;
        ysum = yf + CNT_W'(yofs_i);
        if (ysum >= H_C) ysum = ysum - H_C;
    end

    assign unused_hi = ^{xm[CNT_W-1:X_W], ysum[CNT_W-1:Y_W]};

    // Stage-1 registers; coordinates and data only move on a real write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= 1'b0;
            clip_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            data_q <= '0;
        end else begin
            wr_q   <= valid_i && keep && !clip;
            clip_q <= valid_i && keep && clip;
            if (valid_i && keep && !clip) begin
                x_q    <= xm[X_W-1:0];
                y_q    <= ysum[Y_W-1:0];
                data_q <= data_i;
            end
        end
    end

    assign wr_o   = wr_q;
    assign clip_o = clip_q;
    assign x_o    = x_q;
    assign y_o    = y_q;
    assign data_o = data_q;

endmodule

// File: rtl/cam_fb_writer.sv
// Camera-to-framebuffer write controller: frame FSM, pixel counters, address
// stage and bank double-buffering. Define CAM_FB_WRITER_STATS_EN to add the
// frame_cnt_o / clip_cnt_o statistics outputs.
//
// state  | meaning
// IDLE   | waiting for sof with enable
// ACTIVE | counting and writing pixels of the current frame
// FLUSH  | draining the write pipeline, then swap banks
module cam_fb_writer
    import cam_pkg::*;
#(
    parameter int PIX_W  = 16,
    parameter int FB_W   = FB_W_DEF,
    parameter int FB_H   = FB_H_DEF,
    parameter int DECIM  = 2,
    parameter int BANKS  = 2,
    parameter int CNT_W  = 11,
    parameter int ADDR_W = calc_addr_w(BANKS, FB_W, FB_H),
    parameter int OFS_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic              mirror_x_i,
    input  logic              flip_y_i,
    input  logic [OFS_W-1:0]  y_offset_i,
    input  logic              sof_i,
    input  logic              eol_i,
    input  logic              eof_i,
    input  logic              pix_valid_i,
    input  logic [PIX_W-1:0]  pix_data_i,
    output logic              fb_we_o,
    output logic [ADDR_W-1:0] fb_waddr_o,
    output logic [PIX_W-1:0]  fb_wdata_o,
    output logic              rd_bank_o,
    output logic              frame_swap_o,
    output logic              busy_o
`ifdef CAM_FB_WRITER_STATS_EN
    ,
    output logic [15:0]       frame_cnt_o,
    output logic [15:0]       clip_cnt_o
`endif
);

    localparam int X_W = $clog2(FB_W);
    localparam int Y_W = $clog2(FB_H);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [ADDR_W-1:0] BANK_SZ = ADDR_W'(FB_W * FB_H);

    state_e            state_q, state_d;
    logic [1:0]        flush_q, flush_d;
    logic              start, accept, swap_d;
    logic [CNT_W-1:0]  col_q, col_d, row_q, row_d, col_cur, row_cur;
    logic              mirror_q, mirror_d, flip_q, flip_d;
    logic [OFS_W-1:0]  ofs_q, ofs_d, ofs_clamp;
    logic              rd_bank_q, wbank_q, swap_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q, addr_d;
    logic [PIX_W-1:0]  wdata_q;
    logic              map_wr, map_clip;
    logic [X_W-1:0]    map_x;
    logic [Y_W-1:0]    map_y;
    logic [PIX_W-1:0]  map_data;

    // Next state; sof in ACTIVE restarts (or quits if disabled), sof in FLUSH is ignored.
    always_comb begin
        state_d = state_q;
        flush_d = flush_q;
        start   = 1'b0;
        swap_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sof_i && enable_i) begin
                    state_d = ACTIVE;
                    start   = 1'b1;
                end
            end
            ACTIVE: begin
                if (sof_i) begin
                    if (enable_i) start = 1'b1;
                    else          state_d = IDLE;
                end else if (eof_i) begin
                    state_d = FLUSH;
                    flush_d = 2'(FLUSH_CYC - 1);
                end
            end
            FLUSH: begin
                if (flush_q == '0) begin
                    state_d = IDLE;
                    swap_d  = 1'b1;
                end else begin
                    flush_d = flush_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept    = pix_valid_i && (start || ((state_q == ACTIVE) && !sof_i));
    assign ofs_clamp = (32'(y_offset_i) >= 32'(FB_H)) ? '0 : y_offset_i;

    // Controls take effect on the sof cycle itself, so a pixel sharing sof already sees them.
    always_comb begin
        mirror_d = mirror_q;
        flip_d   = flip_q;
        ofs_d    = ofs_q;
        if (start) begin
            mirror_d = mirror_x_i;
            flip_d   = flip_y_i;
            ofs_d    = ofs_clamp;
        end
    end

    // Pixel takes the current (col,row) before the increment; eol wins over the column step.
    always_comb begin
        col_cur = start ? '0 : col_q;
        row_cur = start ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (start || (state_q == ACTIVE)) begin
            col_d = col_cur;
            row_d = row_cur;
            if (eol_i) begin
                col_d = '0;
                row_d = (row_cur == CNT_MAX) ? row_cur : row_cur + 1'b1;
            end else if (pix_valid_i) begin
                col_d = (col_cur == CNT_MAX) ? col_cur : col_cur + 1'b1;
            end
        end
    end

    cam_fb_map #(
        .PIX_W (PIX_W),
        .FB_W  (FB_W),
        .FB_H  (FB_H),
        .DECIM (DECIM),
        .CNT_W (CNT_W),
        .OFS_W (OFS_W)
    ) u_map (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (accept),
        .col_i    (col_cur),
        .row_i    (row_cur),
        .mirror_i (mirror_d),
        .flip_i   (flip_d),
        .yofs_i   (ofs_d),
        .data_i   (pix_data_i),
        .wr_o     (map_wr),
        .clip_o   (map_clip),
        .x_o      (map_x),
        .y_o      (map_y),
        .data_o   (map_data)
    );

    // Linear address from bank, row and column without a multiplier.
    always_comb begin
        addr_d = ADDR_W'(mul_const(32'(map_y), FB_W)) + ADDR_W'(map_x) + (wbank_q ? BANK_SZ : '0);
    end

    // FSM, counters, latched controls, banks and the stage-2 write registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            flush_q   <= '0;
            col_q     <= '0;
            row_q     <= '0;
            mirror_q  <= 1'b0;
            flip_q    <= 1'b0;
            ofs_q     <= '0;
            rd_bank_q <= 1'b0;
            wbank_q   <= (BANKS == 2) ? 1'b1 : 1'b0;
            swap_q    <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            state_q  <= state_d;
            flush_q  <= flush_d;
            col_q    <= col_d;
            row_q    <= row_d;
            mirror_q <= mirror_d;
            flip_q   <= flip_d;
            ofs_q    <= ofs_d;
            swap_q   <= swap_d;
            if (swap_d && (BANKS == 2)) begin
                rd_bank_q <= ~rd_bank_q;
                wbank_q   <= rd_bank_q;
            end
            we_q <= map_wr;
            if (map_wr) begin
                waddr_q <= addr_d;
                wdata_q <= map_data;
            end
        end
    end

    assign fb_we_o      = we_q;
    assign fb_waddr_o   = waddr_q;
    assign fb_wdata_o   = wdata_q;
    assign rd_bank_o    = rd_bank_q;
    assign frame_swap_o = swap_q;
    assign busy_o       = (state_q != IDLE);

`ifdef CAM_FB_WRITER_STATS_EN
    logic [15:0] frame_cnt_q, clip_cnt_q;

    // Saturating statistics; the clip count restarts with every accepted frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            clip_cnt_q  <= '0;
        end else begin
            if (swap_d && (frame_cnt_q != '1)) frame_cnt_q <= frame_cnt_q + 1'b1;
            if (start)                                clip_cnt_q <= '0;
            else if (map_clip && (clip_cnt_q != '1)) clip_cnt_q <= clip_cnt_q + 1'b1;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
    assign clip_cnt_o  = clip_cnt_q;
`else
    logic unused_clip;
    assign unused_clip = map_clip;
`endif

endmodule
